// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, 1-entry skid buffer, redirect squash.
// First valid_dec 2 cycles after reset with 1-cycle memory; pc_stall holds the output slot and parks one return in the skid.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        flush_fe,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_dec,
  output logic [31:0] instr_dec,
  output logic [31:0] pc_dec
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] req_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        accept;
  logic        consume;

  // A full skid means the output is blocked, so no new fetch is launched.
  assign imem_req  = (state == IDLE) && !skid_valid && !flush_fe && !rst;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_gnt;
  assign consume   = valid_dec && !pc_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = WAIT;
      end
      WAIT: begin
        // A return in the flush cycle is dropped here, so go straight back to IDLE.
        if (imem_rvalid)   state_nxt = IDLE;
        else if (flush_fe) state_nxt = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc     <= 32'd0;
      valid_dec  <= 1'b0;
      instr_dec  <= NOP_INSTR;
      pc_dec     <= 32'd0;
      skid_valid <= 1'b0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
    end else begin
      if (flush_fe) begin
        pc_q <= redirect_target & 32'hFFFF_FFFC;
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end

      if (accept) begin
        req_pc <= pc_q;
      end

      if (flush_fe) begin
        valid_dec  <= 1'b0;
        instr_dec  <= NOP_INSTR;
        skid_valid <= 1'b0;
      end else if (skid_valid && consume) begin
        valid_dec  <= 1'b1;
        instr_dec  <= skid_instr;
        pc_dec     <= skid_pc;
        skid_valid <= 1'b0;
      end else if ((state == WAIT) && imem_rvalid) begin
        if (!valid_dec || consume) begin
          valid_dec <= 1'b1;
          instr_dec <= imem_rdata;
          pc_dec    <= req_pc;
        end else begin
          skid_valid <= 1'b1;
          skid_instr <= imem_rdata;
          skid_pc    <= req_pc;
        end
      end else if (consume) begin
        valid_dec <= 1'b0;
        instr_dec <= NOP_INSTR;
      end
    end
  end

  a_skid_implies_out: assert property (@(posedge clk) disable iff (rst)
    skid_valid |-> valid_dec);
  a_single_outstanding: assert property (@(posedge clk) disable iff (rst)
    (state != IDLE) |-> !imem_req);
  a_idle_rvalid_ignored: assert property (@(posedge clk) disable iff (rst)
    ((state == IDLE) && imem_rvalid && !valid_dec) |=> !valid_dec);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle tables, directed multi-cycle corners, randomized run vs. stream model.
module tb_fetch_unit;
  localparam logic [31:0] PAT = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_stall = 1'b0;
  logic        flush_fe = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req, valid_dec;
  logic [31:0] imem_addr, instr_dec, pc_dec;
  logic        imem_req2, valid_dec2;
  logic [31:0] imem_addr2, instr_dec2, pc_dec2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .flush_fe(flush_fe),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_dec(valid_dec), .instr_dec(instr_dec), .pc_dec(pc_dec)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .flush_fe(flush_fe),
    .redirect_target(redirect_target), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_dec(valid_dec2), .instr_dec(instr_dec2), .pc_dec(pc_dec2)
  );

  typedef struct {
    logic        r, st, fl, g, rv;
    logic [31:0] tg, rd;
    logic        e_req, e_vld;
    logic [31:0] e_addr, e_instr, e_pc;
    logic        chk2, e_req2, e_vld2;
    logic [31:0] e_addr2, e_instr2, e_pc2;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(logic r, st, fl, logic [31:0] tg, logic g, rv, logic [31:0] rd,
                             logic er, logic [31:0] ea, logic ev, logic [31:0] ei, ep);
    vec_t x;
    x = '{r: r, st: st, fl: fl, g: g, rv: rv, tg: tg, rd: rd, e_req: er, e_vld: ev,
          e_addr: ea, e_instr: ei, e_pc: ep, chk2: 1'b0, e_req2: 1'b0, e_vld2: 1'b0,
          e_addr2: 32'd0, e_instr2: 32'd0, e_pc2: 32'd0};
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, st, fl, input logic [31:0] tg, input logic g, rv,
                       input logic [31:0] rd);
    @(negedge clk);
    rst = r; pc_stall = st; flush_fe = fl; redirect_target = tg;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    #1;
  endtask

  // Random-phase model state: memory slot plus expected fetch and delivery streams.
  logic        pend_vld, hold_prev, rv, st, fl, g;
  int          pend_cnt, consumed;
  logic [31:0] pend_addr, mfetch, mnext, hold_pc, hold_instr, rd, tg;

  initial begin
    // Reset release, 1-cycle memory, then redirect while a request is in flight.
    vt.push_back(v(1,0,0,0,1,0,0,                  0,0,        0,NOP,            0));
    vt.push_back(v(0,0,0,0,1,0,0,                  1,32'h0,    0,NOP,            0));
    vt.push_back(v(0,0,0,0,1,1,32'h0^PAT,          0,0,        0,NOP,            0));
    vt.push_back(v(0,0,0,0,1,0,0,                  1,32'h4,    1,32'h0^PAT,      32'h0));
    vt.push_back(v(0,0,0,0,1,1,32'h4^PAT,          0,0,        0,NOP,            32'h0));
    vt.push_back(v(0,0,0,0,1,0,0,                  1,32'h8,    1,32'h4^PAT,      32'h4));
    vt.push_back(v(0,0,0,0,1,1,32'h8^PAT,          0,0,        0,NOP,            32'h4));
    vt.push_back(v(0,0,0,0,0,0,0,                  1,32'hC,    1,32'h8^PAT,      32'h8));
    vt.push_back(v(0,0,0,0,0,0,0,                  1,32'hC,    0,NOP,            32'h8));
    vt.push_back(v(0,0,0,0,1,0,0,                  1,32'hC,    0,NOP,            32'h8));
    vt.push_back(v(0,0,1,32'h1003,1,0,0,           0,0,        0,NOP,            32'h8));
    vt.push_back(v(0,0,0,0,1,0,0,                  0,0,        0,NOP,            32'h8));
    vt.push_back(v(0,0,0,0,1,1,32'hC^PAT,          0,0,        0,NOP,            32'h8));
    vt.push_back(v(0,0,0,0,1,0,0,                  1,32'h1000, 0,NOP,            32'h8));
    vt.push_back(v(0,0,0,0,1,1,32'h1000^PAT,       0,0,        0,NOP,            32'h8));
    vt.push_back(v(0,0,0,0,0,0,0,                  1,32'h1004, 1,32'h1000^PAT,   32'h1000));
    vt.push_back(v(0,0,0,0,0,0,0,                  1,32'h1004, 0,NOP,            32'h1000));
    vt[1].chk2 = 1; vt[1].e_req2 = 1; vt[1].e_addr2 = 32'hFFFF_FFFC;
    vt[1].e_vld2 = 0; vt[1].e_instr2 = NOP; vt[1].e_pc2 = 32'h0;
    vt[3].chk2 = 1; vt[3].e_req2 = 1; vt[3].e_addr2 = 32'h0;
    vt[3].e_vld2 = 1; vt[3].e_instr2 = 32'h0^PAT; vt[3].e_pc2 = 32'hFFFF_FFFC;

    drive(1,0,0,0,1,0,0);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].st, vt[i].fl, vt[i].tg, vt[i].g, vt[i].rv, vt[i].rd);
      chk($sformatf("tbl%0d.req", i), imem_req, vt[i].e_req);
      if (vt[i].e_req) chk($sformatf("tbl%0d.addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("tbl%0d.vld", i), valid_dec, vt[i].e_vld);
      chk($sformatf("tbl%0d.instr", i), instr_dec, vt[i].e_instr);
      chk($sformatf("tbl%0d.pc", i), pc_dec, vt[i].e_pc);
      if (vt[i].chk2) begin
        chk($sformatf("tbl%0d.wrap_req", i), imem_req2, vt[i].e_req2);
        chk($sformatf("tbl%0d.wrap_addr", i), imem_addr2, vt[i].e_addr2);
        chk($sformatf("tbl%0d.wrap_vld", i), valid_dec2, vt[i].e_vld2);
        chk($sformatf("tbl%0d.wrap_instr", i), instr_dec2, vt[i].e_instr2);
        chk($sformatf("tbl%0d.wrap_pc", i), pc_dec2, vt[i].e_pc2);
      end
    end

    // Stall for 5 cycles with a return arriving: skid fills, then drains in order.
    drive(0,0,0,0,1,0,0);               chk("skid.req0", imem_addr, 32'h1004);
    drive(0,0,0,0,1,1,32'h1004^PAT);
    drive(0,1,0,0,1,0,0);               chk("skid.addr", imem_addr, 32'h1008);
    chk("skid.pc_s0", pc_dec, 32'h1004);  chk("skid.instr_s0", instr_dec, 32'h1004^PAT);
    drive(0,1,0,0,1,1,32'h1008^PAT);    chk("skid.pc_s1", pc_dec, 32'h1004);
    for (int k = 2; k < 5; k++) begin
      drive(0,1,0,0,1,0,0);
      chk($sformatf("skid.req_s%0d", k), imem_req, 1'b0);
      chk($sformatf("skid.vld_s%0d", k), valid_dec, 1'b1);
      chk($sformatf("skid.pc_s%0d", k), pc_dec, 32'h1004);
    end
    drive(0,0,0,0,0,0,0);               chk("skid.rel_pc", pc_dec, 32'h1004);
    drive(0,0,0,0,0,0,0);
    chk("skid.out_vld", valid_dec, 1'b1); chk("skid.out_pc", pc_dec, 32'h1008);
    chk("skid.out_instr", instr_dec, 32'h1008^PAT);
    chk("skid.req_after", imem_req, 1'b1); chk("skid.addr_after", imem_addr, 32'h100C);
    drive(0,0,0,0,0,0,0);               chk("skid.drained", valid_dec, 1'b0);

    // Flush in the same cycle as a return while stalled.
    drive(0,0,0,0,1,0,0);               chk("fr.addr", imem_addr, 32'h100C);
    drive(0,0,0,0,1,1,32'h100C^PAT);
    drive(0,1,0,0,1,0,0);               chk("fr.pc", pc_dec, 32'h100C);
    drive(0,1,1,32'h2000,1,1,32'h1010^PAT); chk("fr.req_flush", imem_req, 1'b0);
    drive(0,1,0,0,0,0,0);
    chk("fr.vld", valid_dec, 1'b0); chk("fr.req", imem_req, 1'b1);
    chk("fr.addr_tgt", imem_addr, 32'h2000);

    // Reset while waiting; the late return must be ignored.
    drive(0,0,0,0,1,0,0);               chk("rw.req", imem_req, 1'b1);
    drive(1,0,0,0,1,0,0);               chk("rw.req_rst", imem_req, 1'b0);
    drive(0,0,0,0,1,1,32'hDEAD_BEEF);
    chk("rw.addr", imem_addr, 32'h0);   chk("rw.vld0", valid_dec, 1'b0);
    drive(0,0,0,0,1,0,0);               chk("rw.vld1", valid_dec, 1'b0);
    drive(0,0,0,0,0,1,32'h0^PAT);       chk("rw.vld2", valid_dec, 1'b0);
    drive(0,0,0,0,0,0,0);
    chk("rw.vld3", valid_dec, 1'b1);    chk("rw.pc3", pc_dec, 32'h0);
    chk("rw.instr3", instr_dec, 32'h0^PAT);

    // Randomized run: every delivered instruction must continue the fetch stream.
    drive(1,0,0,0,0,0,0);
    drive(1,0,0,0,0,0,0);
    pend_vld = 0; pend_cnt = 0; pend_addr = 0; hold_prev = 0; consumed = 0;
    hold_pc = 0; hold_instr = 0; mfetch = 32'h0; mnext = 32'h0;
    for (int n = 0; n < 4000; n++) begin
      rv = 1'b0; rd = $urandom;
      if (pend_vld) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rv = 1'b1; rd = pend_addr ^ PAT; pend_vld = 1'b0;
        end
      end
      st = ($urandom % 3) == 0;
      fl = ($urandom % 20) == 0;
      tg = $urandom;
      g  = ($urandom % 4) != 0;
      drive(0, st, fl, tg, g, rv, rd);
      if (hold_prev) begin
        chk("rnd.hold_vld", valid_dec, 1'b1);
        chk("rnd.hold_pc", pc_dec, hold_pc);
        chk("rnd.hold_instr", instr_dec, hold_instr);
      end
      if (fl) chk("rnd.req_in_flush", imem_req, 1'b0);
      if (imem_req && g) begin
        chk("rnd.fetch_addr", imem_addr, mfetch);
        chk("rnd.one_outstanding", pend_vld || rv, 1'b0);
        pend_vld = 1'b1; pend_addr = imem_addr; pend_cnt = $urandom_range(1, 3);
      end
      if (valid_dec && !st && !fl) begin
        chk("rnd.pc", pc_dec, mnext);
        chk("rnd.instr", instr_dec, mnext ^ PAT);
        mnext += 32'd4;
        consumed++;
      end
      hold_prev = valid_dec && st && !fl;
      hold_pc = pc_dec; hold_instr = instr_dec;
      if (fl) begin
        mfetch = tg & 32'hFFFF_FFFC;
        mnext  = tg & 32'hFFFF_FFFC;
      end else if (imem_req && g) begin
        mfetch += 32'd4;
      end
    end
    chk("rnd.progress", consumed > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end. It consumes the hazard unit's pc_stall and flush_fe outputs together with the branch redirect target, and drives instruction-memory requests. It presents a valid/instruction/PC triple to the decode stage. It allows one outstanding memory request, holds returned instructions across stalls in a 1-entry skid buffer, and discards in-flight responses squashed by a redirect.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
NOP_INSTR, 32'h0000_0013, instruction value driven on instr_dec while invalid/after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
pc_stall  input  1  decode not accepting; hold presented instruction
flush_fe  input  1  taken-branch redirect; squash fetch state, load redirect_target
redirect_target  input  32  new fetch PC, sampled when flush_fe=1
imem_req  output  1  request valid
imem_addr  output  32  request word address (= pc_q)
imem_gnt  input  1  memory accepts request this cycle (handshake imem_req & imem_gnt)
imem_rvalid  input  1  response valid, >=1 cycle after accept, exactly one per accepted request
imem_rdata  input  32  response instruction
valid_dec  output  1  instr_dec/pc_dec hold a live instruction
instr_dec  output  32  instruction to decode
pc_dec  output  32  PC of instr_dec

Behaviour:
- State: pc_q[31:0], req_pc[31:0], FSM {IDLE, WAIT, DROP}, out slot {valid_dec, instr_dec, pc_dec}, skid {skid_valid, skid_instr, skid_pc}.
- Reset (rst=1 at edge): pc_q=RESET_PC, FSM=IDLE, valid_dec=0, instr_dec=NOP_INSTR, pc_dec=0, skid_valid=0, req_pc=0. imem_req=0 while rst=1. Reset mid-request returns FSM to IDLE; a late imem_rvalid arriving in IDLE is ignored.
- imem_req = (FSM==IDLE) & !skid_valid & !flush_fe & !rst (combinational). imem_addr = pc_q.
- Accept (imem_req & imem_gnt): req_pc<=pc_q; pc_q<=pc_q+4, modulo 2^32 (0xFFFF_FFFC wraps to 0); FSM->WAIT. No gnt: hold request and address unchanged.
- Consume = valid_dec & !pc_stall.
- Out slot update, priority order:
  1) flush_fe: valid_dec<=0, skid_valid<=0. pc_q<={redirect_target[31:2],2'b00}. FSM: WAIT->DROP; DROP stays DROP; IDLE stays IDLE. If imem_rvalid arrives in the same cycle in WAIT/DROP, discard it and FSM->IDLE. flush_fe overrides pc_stall.
  2) skid_valid & consume: out<=skid, skid_valid<=0.
  3) WAIT & imem_rvalid: if !valid_dec or consume: out<={1,imem_rdata,req_pc}. Otherwise (stalled and occupied): skid<={1,imem_rdata,req_pc}. In both cases FSM->IDLE.
  4) consume with no replacement: valid_dec<=0, instr_dec<=NOP_INSTR.
- DROP & imem_rvalid (no flush): data discarded, FSM->IDLE.
- pc_stall with valid_dec=0 has no effect on acceptance of returning data.
- Latency: with imem_gnt=1 and 1-cycle memory, the first valid_dec is 2 cycles after reset deasserts. Steady-state throughput is 1 instruction per 2 cycles (one outstanding request).
- Invariants (assert): skid_valid implies valid_dec. At most one outstanding request. imem_rvalid never consumed in IDLE.

Test Plan:
- Reset release, gnt=1, 1-cycle rdata=addr^0xA5A5A5A5 -> valid_dec pulses with pc_dec sequence 0x0,0x4,0x8, instr_dec matching. Before the first one, instr_dec=0x13, valid_dec=0.
- pc_stall=1 held 5 cycles while out occupied and one response returns -> skid fills, imem_req=0. pc_dec is unchanged throughout. On release, the skid instruction is presented the next cycle and ordering is preserved.
- flush_fe=1, redirect_target=0x0000_1003, while in WAIT -> response delivered 2 cycles later is dropped. Next imem_addr=0x0000_1000, and the next valid_dec has pc_dec=0x1000.
- flush_fe coincident with imem_rvalid and pc_stall=1 -> valid_dec=0 and skid empty next cycle. FSM is IDLE, and a request to the target issues the following cycle.
- RESET_PC=0xFFFF_FFFC -> second request addr=0x0000_0000.
- rst asserted while in WAIT, rvalid arrives after rst drops -> response ignored, first fetch addr=RESET_PC, no spurious valid_dec.
